// File: rtl/tpu_mm_sequencer_if.sv
// Control/status bundle between the TPU memory-mapped decode (master) and the
// matrix-multiply sequencer (slave).
interface tpu_mm_sequencer_if #(
   parameter int CNTW = 5
);
   logic            start;
   logic            stall;
   logic            abort;
   logic            host_req;
   logic            en_mem;
   logic            en_sys;
   logic            busy;
   logic            done;
   logic            host_gnt;
   logic            host_err;
   logic [CNTW-1:0] cnt;
   logic [15:0]     stall_cnt;

   modport master (
      output start, stall, abort, host_req,
      input  en_mem, en_sys, busy, done, host_gnt, host_err, cnt, stall_cnt
   );

   modport slave (
      input  start, stall, abort, host_req,
      output en_mem, en_sys, busy, done, host_gnt, host_err, cnt, stall_cnt
   );
endinterface

// File: rtl/tpu_mm_sequencer.sv
// One skewed DIMxDIM pass: 3*DIM-2 enabled cycles then a done pulse; host access only while idle.
// Optional stall-cycle counter enabled by defining TPU_SEQ_STALLCNT_EN.
module tpu_mm_sequencer #(
   parameter int DIM  = 8,
   parameter int CNTW = $clog2(3*DIM-1)
) (
   input  logic                clk,
   input  logic                rst_n,
   tpu_mm_sequencer_if.slave   bus
);
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

   localparam logic [CNTW-1:0] LAST = CNTW'(3*DIM-3);

   state_t          state_q, state_d;
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic            host_err_q, host_err_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         host_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         host_err_q <= host_err_d;
      end
   end

   // abort wins over stall and completion, and freezes cnt where it was
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      host_err_d = bus.host_req && (state_q != IDLE);
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = RUN;
               cnt_d   = '0;
            end
         end
         RUN: begin
            if (bus.abort) begin
               state_d = IDLE;
            end else if (!bus.stall) begin
               cnt_d = cnt_q + CNTW'(1);
               if (cnt_q == LAST) state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.en_mem   = (state_q == RUN) && !bus.stall;
      bus.en_sys   = (state_q == RUN) && !bus.stall;
      bus.busy     = (state_q != IDLE);
      bus.done     = (state_q == DONE);
      bus.host_gnt = bus.host_req && (state_q == IDLE);
      bus.host_err = host_err_q;
      bus.cnt      = cnt_q;
   end

`ifdef TPU_SEQ_STALLCNT_EN
   logic [15:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (state_q == IDLE && bus.start) begin
         stall_cnt_d = '0;
      end else if (state_q == RUN && !bus.abort && bus.stall && stall_cnt_q != 16'hFFFF) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) stall_cnt_q <= '0;
      else        stall_cnt_q <= stall_cnt_d;
   end

   assign bus.stall_cnt = stall_cnt_q;
`else
   assign bus.stall_cnt = '0;
`endif
endmodule

// File: tb/tb_tpu_mm_sequencer.sv
// Directed bench for tpu_mm_sequencer (DIM=8): inputs driven just after posedge, outputs sampled at negedge.
module tb_tpu_mm_sequencer;
   localparam int DIM  = 8;
   localparam int CNTW = $clog2(3*DIM-1);
`ifdef TPU_SEQ_STALLCNT_EN
   localparam int STALL_EXP = 3;
`else
   localparam int STALL_EXP = 0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   n_run  = 0;
   int   n_fail = 0;
   int   exp_cnt, en_cnt, done_n, done_at;
   logic exp_en;

   tpu_mm_sequencer_if #(.CNTW(CNTW)) bus();

   tpu_mm_sequencer #(.DIM(DIM), .CNTW(CNTW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_run++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic look;
      @(negedge clk);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".en_mem"},    32'(bus.en_mem),    0);
      chk({tag, ".en_sys"},    32'(bus.en_sys),    0);
      chk({tag, ".busy"},      32'(bus.busy),      0);
      chk({tag, ".done"},      32'(bus.done),      0);
      chk({tag, ".host_err"},  32'(bus.host_err),  0);
      chk({tag, ".cnt"},       32'(bus.cnt),       0);
      chk({tag, ".stall_cnt"}, 32'(bus.stall_cnt), 0);
   endtask

   initial begin
      bus.start = 1'b0; bus.stall = 1'b0; bus.abort = 1'b0; bus.host_req = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      chk_all_zero("reset");
      chk("reset.host_gnt", 32'(bus.host_gnt), 0);
      #10 rst_n = 1'b1;

      // host access while idle
      tick; bus.host_req = 1'b1;
      look; chk("idle.host_gnt", 32'(bus.host_gnt), 1);
      chk("idle.host_err", 32'(bus.host_err), 0);
      tick; bus.host_req = 1'b0;
      look; chk("idle.host_err_next", 32'(bus.host_err), 0);

      // basic pass
      tick; bus.start = 1'b1;
      look; chk("basic.c0.busy", 32'(bus.busy), 0);
      tick; bus.start = 1'b0;
      for (int c = 1; c <= 22; c++) begin
         look;
         chk($sformatf("basic.c%0d.en_mem", c), 32'(bus.en_mem), 1);
         chk($sformatf("basic.c%0d.en_sys", c), 32'(bus.en_sys), 1);
         chk($sformatf("basic.c%0d.cnt", c), 32'(bus.cnt), 32'(c-1));
         chk($sformatf("basic.c%0d.done", c), 32'(bus.done), 0);
         tick;
      end
      look;
      chk("basic.c23.done", 32'(bus.done), 1);
      chk("basic.c23.busy", 32'(bus.busy), 1);
      chk("basic.c23.en", 32'(bus.en_mem), 0);
      chk("basic.c23.cnt", 32'(bus.cnt), 22);
      tick; look;
      chk("basic.c24.busy", 32'(bus.busy), 0);
      chk("basic.c24.done", 32'(bus.done), 0);

      // stall on cycles 5-7
      tick; bus.start = 1'b1;
      look;
      tick; bus.start = 1'b0;
      exp_cnt = 0;
      for (int c = 1; c <= 26; c++) begin
         bus.stall = (c >= 5 && c <= 7);
         look;
         exp_en = (c <= 25) && !(c >= 5 && c <= 7);
         chk($sformatf("stall.c%0d.en_mem", c), 32'(bus.en_mem), 32'(exp_en));
         chk($sformatf("stall.c%0d.en_sys", c), 32'(bus.en_sys), 32'(exp_en));
         chk($sformatf("stall.c%0d.cnt", c), 32'(bus.cnt), 32'(exp_cnt));
         chk($sformatf("stall.c%0d.done", c), 32'(bus.done), 32'(c == 26));
         if (exp_en) exp_cnt++;
         tick;
      end
      bus.stall = 1'b0;
      look;
      chk("stall.c27.busy", 32'(bus.busy), 0);
      chk("stall.c27.stall_cnt", 32'(bus.stall_cnt), 32'(STALL_EXP));

      // abort at cycle 10, restart at cycle 12
      tick; bus.start = 1'b1;
      look;
      tick; bus.start = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         bus.abort = (c == 10);
         look;
         if (c == 10) chk("abort.c10.cnt", 32'(bus.cnt), 9);
         tick;
      end
      bus.abort = 1'b0;
      look;
      chk("abort.c11.busy", 32'(bus.busy), 0);
      chk("abort.c11.done", 32'(bus.done), 0);
      chk("abort.c11.cnt", 32'(bus.cnt), 9);
      tick; bus.start = 1'b1;
      look; chk("abort.c12.busy", 32'(bus.busy), 0);
      tick; bus.start = 1'b0;
      en_cnt = 0; done_n = 0; done_at = -1;
      for (int c = 13; c <= 40; c++) begin
         look;
         if (bus.en_mem) en_cnt++;
         if (bus.done) begin
            done_n++;
            done_at = c;
         end
         tick;
      end
      chk("abort.restart.en_cycles", 32'(en_cnt), 22);
      chk("abort.restart.done_at", 32'(done_at), 35);
      chk("abort.restart.done_n", 32'(done_n), 1);

      // host request refused mid-pass
      bus.start = 1'b1;
      look;
      tick; bus.start = 1'b0;
      repeat (3) tick;
      bus.host_req = 1'b1;
      look;
      chk("host.c4.gnt", 32'(bus.host_gnt), 0);
      chk("host.c4.err", 32'(bus.host_err), 0);
      tick; bus.host_req = 1'b0;
      look; chk("host.c5.err", 32'(bus.host_err), 1);
      tick;
      look; chk("host.c6.err", 32'(bus.host_err), 0);
      repeat (25) tick;

      // start while busy and in the DONE cycle
      bus.start = 1'b1;
      look;
      tick; bus.start = 1'b0;
      done_n = 0;
      for (int c = 1; c <= 30; c++) begin
         bus.start = (c == 8 || c == 23);
         look;
         if (bus.done) done_n++;
         if (c == 9)  chk("busystart.c9.cnt", 32'(bus.cnt), 8);
         if (c == 23) chk("busystart.c23.done", 32'(bus.done), 1);
         if (c == 24) chk("busystart.c24.busy", 32'(bus.busy), 0);
         if (c == 25) chk("busystart.c25.busy", 32'(bus.busy), 0);
         tick;
      end
      bus.start = 1'b0;
      chk("busystart.done_n", 32'(done_n), 1);

      // start together with host_req in IDLE
      bus.start = 1'b1; bus.host_req = 1'b1;
      look; chk("both.gnt", 32'(bus.host_gnt), 1);
      tick; bus.start = 1'b0; bus.host_req = 1'b0;
      look;
      chk("both.next.busy", 32'(bus.busy), 1);
      chk("both.next.en", 32'(bus.en_mem), 1);
      chk("both.next.err", 32'(bus.host_err), 0);
      repeat (24) tick;

      // async reset at cycle 15 of a pass
      bus.start = 1'b1;
      look;
      tick; bus.start = 1'b0;
      for (int c = 1; c <= 14; c++) begin
         bus.stall = (c == 3);
         tick;
      end
      bus.stall = 1'b0;
      look;
      chk("rst.c15.busy", 32'(bus.busy), 1);
      #1 rst_n = 1'b0;
      #1 chk_all_zero("rst.async");
      bus.host_req = 1'b1;
      #1 chk("rst.host_gnt", 32'(bus.host_gnt), 1);
      rst_n = 1'b1;
      tick;
      look;
      chk("rst.after.busy", 32'(bus.busy), 0);
      chk("rst.after.gnt1", 32'(bus.host_gnt), 1);
      tick; bus.host_req = 1'b0;
      look; chk("rst.after.gnt0", 32'(bus.host_gnt), 0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
